// File: rtl/reg_bank_mp.sv
// ---------------------------------------------------------------------------
// reg_bank_mp -- parametrised multi-port register bank
//
// One storage array holds the general-purpose registers, the kernel
// register (KR, index REG_NUM-2) and the program counter (PC, index
// REG_NUM-1). Write ports have a fixed priority (highest-numbered port
// wins), KR writes are gated by kernel mode, the PC is only changed through
// pc_we_i / pc_inc_i, and a per-register busy scoreboard tracks registers
// that have an issued-but-not-yet-written producer.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rd_addr_i       NRD packed read addresses   (port i = [i*DIR +: DIR])
//   rd_data_o       NRD packed registered read data (port i = [i*BUS +: BUS])
//   rd_busy_o       registered busy flag of each read port's register
//   we_i            NWR write enables
//   wr_addr_i       NWR packed write addresses
//   wr_data_i       NWR packed write data
//   kmode_i         kernel mode, qualifies KR writes
//   issue_valid_i   an instruction writing issue_addr_i was issued
//   issue_addr_i    destination register of the issued instruction
//   pc_we_i         load PC from pc_in_i (priority over pc_inc_i)
//   pc_inc_i        PC += PC_STEP (wraps modulo 2**BUS)
//   pc_in_i         PC load value
//   pc_out_o        current PC
//   busy_o          scoreboard vector
//   kr_viol_o       one-cycle pulse after a KR write attempted with kmode_i=0
//
// Build option:
//   REG_BANK_BYPASS_EN  when defined, reads of a register being written in
//                       the same cycle capture the winning write data and
//                       the post-edge busy value.
// ---------------------------------------------------------------------------
module reg_bank_mp #(
    parameter int             BUS      = 32,
    parameter int             DIR      = 4,
    parameter int             NRD      = 4,
    parameter int             NWR      = 2,
    parameter logic [BUS-1:0] RESET_PC = '0,
    parameter logic [BUS-1:0] PC_STEP  = BUS'(4)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*DIR-1:0]    rd_addr_i,
    output logic [NRD*BUS-1:0]    rd_data_o,
    output logic [NRD-1:0]        rd_busy_o,
    input  logic [NWR-1:0]        we_i,
    input  logic [NWR*DIR-1:0]    wr_addr_i,
    input  logic [NWR*BUS-1:0]    wr_data_i,
    input  logic                  kmode_i,
    input  logic                  issue_valid_i,
    input  logic [DIR-1:0]        issue_addr_i,
    input  logic                  pc_we_i,
    input  logic                  pc_inc_i,
    input  logic [BUS-1:0]        pc_in_i,
    output logic [BUS-1:0]        pc_out_o,
    output logic [(2**DIR)-1:0]   busy_o,
    output logic                  kr_viol_o
);

    localparam int             REG_NUM = 2**DIR;
    localparam int             PC_IDX  = REG_NUM - 1;
    localparam logic [DIR-1:0] PC_ADDR = DIR'(REG_NUM - 1);
    localparam logic [DIR-1:0] KR_ADDR = DIR'(REG_NUM - 2);

    // Storage and registered outputs
    logic [BUS-1:0]     regs_q    [REG_NUM];
    logic [REG_NUM-1:0] busy_q,   busy_d;
    logic [BUS-1:0]     rd_data_q [NRD];
    logic [BUS-1:0]     rd_data_d [NRD];
    logic [NRD-1:0]     rd_busy_q, rd_busy_d;
    logic               kr_viol_q, kr_viol_d;
    logic [BUS-1:0]     pc_d;

    // Unpacked views of the packed port buses
    logic [DIR-1:0]     rd_addr_a [NRD];
    logic [DIR-1:0]     wr_addr_a [NWR];
    logic [BUS-1:0]     wr_data_a [NWR];

    // Resolved writes: per port acceptance, per register hit and value
    logic [NWR-1:0]     wr_ok;
    logic [REG_NUM-1:0] wr_hit;
    logic [BUS-1:0]     wr_val    [REG_NUM];

    for (genvar i = 0; i < NRD; i++) begin : g_rd_port
        assign rd_addr_a[i]              = rd_addr_i[i*DIR +: DIR];
        assign rd_data_o[i*BUS +: BUS]   = rd_data_q[i];
    end

    for (genvar p = 0; p < NWR; p++) begin : g_wr_port
        assign wr_addr_a[p] = wr_addr_i[p*DIR +: DIR];
        assign wr_data_a[p] = wr_data_i[p*BUS +: BUS];
    end

    // Port acceptance: PC-index writes are dropped, KR writes need kmode_i.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ok     = '0;
        kr_viol_d = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            if (we_i[p]) begin
                if (wr_addr_a[p] == PC_ADDR) begin
                    wr_ok[p] = 1'b0;
                end else if (wr_addr_a[p] == KR_ADDR && !kmode_i) begin
                    kr_viol_d = 1'b1;
                end else begin
                    wr_ok[p] = 1'b1;
                end
            end
        end
    end

    // Per-register write resolution. Ports are scanned in ascending order
    // so the highest-numbered accepted port overwrites lower ones.
    always_comb begin
        // NOTE: blocking assignments in combinational logic give the
        // "later statement wins" ordering the priority rule relies on.
        for (int r = 0; r < REG_NUM; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int p = 0; p < NWR; p++) begin
                if (wr_ok[p] && wr_addr_a[p] == DIR'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data_a[p];
                end
            end
        end
    end

    // PC next state: load beats increment.
    always_comb begin
        pc_d = regs_q[PC_IDX];
        if (pc_we_i) begin
            pc_d = pc_in_i;
        end else if (pc_inc_i) begin
            pc_d = regs_q[PC_IDX] + PC_STEP;
        end
    end

    // Scoreboard: accepted writes clear, issue sets; set applied last so it
    // wins a same-cycle conflict. The PC entry is never set.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (issue_valid_i && issue_addr_i != PC_ADDR) begin
            busy_d[issue_addr_i] = 1'b1;
        end
    end

    // Read capture
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_data_d[i] = regs_q[rd_addr_a[i]];
            rd_busy_d[i] = busy_q[rd_addr_a[i]];
`ifdef REG_BANK_BYPASS_EN
            if (wr_hit[rd_addr_a[i]]) begin
                rd_data_d[i] = wr_val[rd_addr_a[i]];
            end
            rd_busy_d[i] = busy_d[rd_addr_a[i]];
`endif
        end
    end

    // Register array, including KR and PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is architectural state with defined reset
            // values, so it is reset explicitly rather than left to RAM.
            for (int r = 0; r < REG_NUM; r++) begin
                regs_q[r] <= (r == PC_IDX) ? RESET_PC : '0;
            end
        end else begin
            for (int r = 0; r < PC_IDX; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_val[r];
                end
            end
            regs_q[PC_IDX] <= pc_d;
        end
    end

    // Scoreboard, read pipeline and violation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            rd_busy_q <= '0;
            kr_viol_q <= 1'b0;
            for (int i = 0; i < NRD; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            rd_busy_q <= rd_busy_d;
            kr_viol_q <= kr_viol_d;
            for (int i = 0; i < NRD; i++) begin
                rd_data_q[i] <= rd_data_d[i];
            end
        end
    end

    assign pc_out_o  = regs_q[PC_IDX];
    assign busy_o    = busy_q;
    assign rd_busy_o = rd_busy_q;
    assign kr_viol_o = kr_viol_q;

endmodule

// File: tb/tb_reg_bank_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_mp -- self-checking bench for reg_bank_mp
//
// Directed scenarios for reset, priority, KR protection, PC wrap/priority,
// scoreboard and read bypass, followed by randomized traffic compared every
// cycle against a behavioural model (plain arrays, PC kept separately).
// Honours REG_BANK_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_reg_bank_mp;

    localparam int          BUS     = 32;
    localparam int          DIR     = 4;
    localparam int          NRD     = 4;
    localparam int          NWR     = 2;
    localparam int          REG_NUM = 16;
    localparam int          PC_I    = 15;
    localparam int          KR_I    = 14;
    localparam logic [31:0] RST_PC  = 32'h100;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRD*DIR-1:0]   rd_addr;
    logic [NRD*BUS-1:0]   rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       we;
    logic [NWR*DIR-1:0]   wr_addr;
    logic [NWR*BUS-1:0]   wr_data;
    logic                 kmode;
    logic                 issue_valid;
    logic [DIR-1:0]       issue_addr;
    logic                 pc_we;
    logic                 pc_inc;
    logic [BUS-1:0]       pc_in;
    logic [BUS-1:0]       pc_out;
    logic [REG_NUM-1:0]   busy;
    logic                 kr_viol;

    reg_bank_mp #(
        .BUS(BUS), .DIR(DIR), .NRD(NRD), .NWR(NWR),
        .RESET_PC(RST_PC), .PC_STEP(32'd4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .we_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .kmode_i(kmode), .issue_valid_i(issue_valid), .issue_addr_i(issue_addr),
        .pc_we_i(pc_we), .pc_inc_i(pc_inc), .pc_in_i(pc_in),
        .pc_out_o(pc_out), .busy_o(busy), .kr_viol_o(kr_viol)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]        m_reg [REG_NUM];   // GPRs + KR; PC held in m_pc
    logic [31:0]        m_pc;
    logic [15:0]        m_busy;
    logic               m_viol;
    logic [31:0]        m_rd [NRD];
    logic [NRD-1:0]     m_rbusy;

    task automatic model_reset();
        for (int r = 0; r < REG_NUM; r++) m_reg[r] = '0;
        for (int i = 0; i < NRD; i++) m_rd[i] = '0;
        m_pc    = RST_PC;
        m_busy  = '0;
        m_viol  = 1'b0;
        m_rbusy = '0;
    endtask

    task automatic idle();
        we          = '0;
        kmode       = 1'b0;
        issue_valid = 1'b0;
        pc_we       = 1'b0;
        pc_inc      = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [3:0] a, input logic [31:0] d);
        we[p]                 = 1'b1;
        wr_addr[p*DIR +: DIR] = a;
        wr_data[p*BUS +: BUS] = d;
    endtask

    task automatic set_rd(input int i, input logic [3:0] a);
        rd_addr[i*DIR +: DIR] = a;
    endtask

    task automatic check_outputs();
        check("pc_out", pc_out, m_pc);
        check("busy", busy, m_busy);
        check("kr_viol", kr_viol, m_viol);
        check("rd_busy", rd_busy, m_rbusy);
        for (int i = 0; i < NRD; i++)
            check($sformatf("rd_data%0d", i), rd_data[i*BUS +: BUS], m_rd[i]);
    endtask

    // One clock: predict from current inputs, clock, commit, compare.
    task automatic tick();
        logic [31:0]    n_reg [REG_NUM];
        logic [15:0]    written;
        logic [15:0]    n_busy;
        logic [31:0]    n_pc;
        logic           n_viol;
        logic [3:0]     a;
        logic [31:0]    n_rd [NRD];
        logic [NRD-1:0] n_rb;
        n_reg   = m_reg;
        written = '0;
        n_viol  = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            if (we[p]) begin
                a = wr_addr[p*DIR +: DIR];
                if (int'(a) == PC_I) begin
                    // PC is not writable through the data ports
                end else if (int'(a) == KR_I && !kmode) begin
                    n_viol = 1'b1;
                end else begin
                    n_reg[a]   = wr_data[p*BUS +: BUS];
                    written[a] = 1'b1;
                end
            end
        end
        n_busy = m_busy & ~written;
        if (issue_valid && int'(issue_addr) != PC_I) n_busy[issue_addr] = 1'b1;
        n_pc = pc_we ? pc_in : (pc_inc ? m_pc + 32'd4 : m_pc);
        for (int i = 0; i < NRD; i++) begin
            a = rd_addr[i*DIR +: DIR];
`ifdef REG_BANK_BYPASS_EN
            n_rd[i] = (int'(a) == PC_I) ? m_pc : n_reg[a];
            n_rb[i] = n_busy[a];
`else
            n_rd[i] = (int'(a) == PC_I) ? m_pc : m_reg[a];
            n_rb[i] = m_busy[a];
`endif
        end
        @(posedge clk);
        #1;
        m_reg   = n_reg;
        m_busy  = n_busy;
        m_pc    = n_pc;
        m_viol  = n_viol;
        m_rd    = n_rd;
        m_rbusy = n_rb;
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, pc_out, RST_PC);
        check({tag, "_busy"}, busy, 16'h0);
        check({tag, "_kr_viol"}, kr_viol, 1'b0);
        check({tag, "_rd_busy"}, rd_busy, 4'h0);
        for (int i = 0; i < NRD; i++)
            check($sformatf("%s_rd_data%0d", tag, i), rd_data[i*BUS +: BUS], 32'h0);
    endtask

    initial begin
        rst_n   = 1'b1;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        issue_addr = '0;
        pc_in   = '0;
        idle();

        // Reset asserted mid-cycle; outputs must settle without a clock edge.
        #7 rst_n = 1'b0;
        #1 check_reset_values("reset");
        #4 rst_n = 1'b1;
        model_reset();

        // Write r3 on port 0, read it on port 2.
        set_wr(0, 4'd3, 32'hDEADBEEF);
        tick();
        idle();
        set_rd(2, 4'd3);
        tick();
        check("r3_read", rd_data[2*BUS +: BUS], 32'hDEADBEEF);

        // Same-address write conflict: port 1 wins.
        set_wr(0, 4'd5, 32'h11);
        set_wr(1, 4'd5, 32'h22);
        tick();
        idle();
        set_rd(0, 4'd5);
        tick();
        check("r5_priority", rd_data[0 +: BUS], 32'h22);

        // KR protection.
        set_rd(1, 4'd14);
        set_wr(0, 4'd14, 32'h55);
        tick();
        check("kr_viol_pulse", kr_viol, 1'b1);
        idle();
        tick();
        check("kr_viol_clear", kr_viol, 1'b0);
        check("kr_unchanged", rd_data[1*BUS +: BUS], 32'h0);
        kmode = 1'b1;
        set_wr(0, 4'd14, 32'h55);
        tick();
        check("kr_kmode_noviol", kr_viol, 1'b0);
        idle();
        tick();
        check("kr_written", rd_data[1*BUS +: BUS], 32'h55);

        // PC wrap and load-over-increment priority.
        pc_we = 1'b1;
        pc_in = 32'hFFFF_FFFC;
        tick();
        idle();
        pc_inc = 1'b1;
        tick();
        check("pc_wrap", pc_out, 32'h0);
        pc_we  = 1'b1;
        pc_in  = 32'h40;
        tick();
        check("pc_we_priority", pc_out, 32'h40);
        idle();

        // Data-port write to the PC index is ignored.
        set_wr(1, 4'd15, 32'hAAAA_AAAA);
        tick();
        check("pc_port_write_ignored", pc_out, 32'h40);
        idle();

        // Scoreboard set / set-wins / clear.
        issue_valid = 1'b1;
        issue_addr  = 4'd7;
        tick();
        check("busy7_set", busy[7], 1'b1);
        set_wr(0, 4'd7, 32'h1234);
        tick();
        check("busy7_set_wins", busy[7], 1'b1);
        idle();
        set_wr(1, 4'd7, 32'h9);
        tick();
        check("busy7_clear", busy[7], 1'b0);
        idle();

        // Issue to the PC index never marks it busy.
        issue_valid = 1'b1;
        issue_addr  = 4'd15;
        tick();
        check("busy_pc_never", busy[15], 1'b0);
        idle();

        // Same-cycle read and write of r3.
        set_rd(3, 4'd3);
        set_wr(0, 4'd3, 32'h77);
        tick();
`ifdef REG_BANK_BYPASS_EN
        check("bypass_r3", rd_data[3*BUS +: BUS], 32'h77);
`else
        check("no_bypass_r3", rd_data[3*BUS +: BUS], 32'hDEADBEEF);
`endif
        idle();

        // Randomized traffic with a reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            we          = NWR'($urandom);
            wr_addr     = NWR*DIR'($urandom);
            wr_data     = {$urandom, $urandom};
            rd_addr     = NRD*DIR'($urandom);
            kmode       = ($urandom_range(0, 3) == 0);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_addr  = DIR'($urandom);
            pc_we       = ($urandom_range(0, 7) == 0);
            pc_inc      = $urandom_range(0, 1) == 1;
            pc_in       = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF8 : $urandom;
            tick();
            if (c == 800) begin
                idle();
                rst_n = 1'b0;
                #1 check_reset_values("mid_reset");
                model_reset();
                #2 rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
- Parametrised multi-port register bank for the processor datapath; successor to the fixed 16x32, 4-read/1-write bank.
- Holds general-purpose registers, one kernel register (KR) and the PC in one storage array.
- Adds configurable read/write port counts, write-port priority, KR write protection, explicit PC update, and a per-register busy scoreboard for hazard detection.
- Sits between decode (read addresses, issue) and writeback (write ports).

Parameters:
- BUS, 32, data width of every register.
- DIR, 4, address width; REG_NUM = 2**DIR registers.
- NRD, 4, number of read ports (1..8).
- NWR, 2, number of write ports (1..4).
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment amount.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*DIR  read addresses; port i = bits [i*DIR +: DIR].
- rd_data  out  NRD*BUS  registered read data, port i packed the same way.
- rd_busy  out  NRD  registered busy flag of the addressed register, per port.
- we  in  NWR  write enables.
- wr_addr  in  NWR*DIR  write addresses.
- wr_data  in  NWR*BUS  write data (WB).
- kmode  in  1  kernel mode; qualifies KR writes.
- issue_valid  in  1  decode issued an instruction that will write issue_addr.
- issue_addr  in  DIR  destination register being issued.
- pc_we  in  1  load PC from pc_in.
- pc_inc  in  1  PC += PC_STEP.
- pc_in  in  BUS  PC load value.
- pc_out  out  BUS  current PC (combinational from the PC register).
- busy  out  REG_NUM  scoreboard vector.
- kr_viol  out  1  one-cycle pulse: illegal KR write attempted.

Behaviour:
- Index map: REG_NUM-1 = PC; REG_NUM-2 = KR; all others are GPRs.
- Reset (async, rst_n=0):
  - all GPRs and KR = 0; PC = RESET_PC.
  - busy = 0; rd_data = 0; rd_busy = 0; kr_viol = 0.
- Reads:
  - Latency 1: rd_data[i] and rd_busy[i] are captured at posedge from rd_addr[i].
  - They reflect pre-edge contents unless bypass is enabled (see Optional Feature).
  - A read of address REG_NUM-1 returns the PC.
- Writes, committed at posedge:
  - A write-port address equal to the PC index is ignored; the PC changes only through pc_we/pc_inc.
  - A write to KR with kmode=0 is ignored, and kr_viol=1 in the following cycle.
  - With kmode=1, KR writes normally.
  - Two or more ports writing the same address in one cycle: the highest-numbered port wins.
- PC, evaluated each posedge:
  - pc_we=1: PC <= pc_in. pc_we has priority over pc_inc.
  - otherwise pc_inc=1: PC <= PC + PC_STEP, modulo 2**BUS (wraps from 0xFFFFFFFC to 0 at defaults).
  - otherwise PC holds.
- Scoreboard, per register r:
  - Any accepted write (we and not ignored) to r clears busy[r].
  - issue_valid with issue_addr==r sets busy[r].
  - Set and clear of the same r in the same cycle: set wins, since the new producer supersedes the old one.
  - issue_addr of the PC index is ignored; busy[REG_NUM-1] stays 0.
  - A rejected KR write (kmode=0) does not clear busy[KR].
- Reset asserted mid-operation: all state returns to reset values immediately, with no clock required.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined: when rd_addr[i] matches an accepted write address in the same cycle, rd_data[i] captures the winning wr_data (same priority rule as writes), and rd_busy[i] reflects the post-edge busy value.
- Undefined: rd_data and rd_busy capture the pre-edge register and busy values. One extra cycle is needed to observe a write.

Test Plan:
- Reset with rst_n=0 mid-cycle, RESET_PC=0x100 -> pc_out=0x100 immediately; all rd_data=0; busy=0.
- Write r3=0xDEADBEEF on port 0, then read r3 on port 2 next cycle -> rd_data[2]=0xDEADBEEF one cycle after rd_addr is applied.
- Same cycle, port0 writes r5=0x11 and port1 writes r5=0x22 -> r5=0x22.
- KR write 0x55 with kmode=0 -> KR unchanged and kr_viol=1 for exactly one cycle. With kmode=1 -> KR=0x55.
- PC=0xFFFFFFFC with pc_inc=1 -> PC=0. pc_we=1 and pc_inc=1 with pc_in=0x40 -> PC=0x40.
- issue r7 -> busy[7]=1. Then issue r7 and write r7 in the same cycle -> busy[7] stays 1. Then write r7 -> busy[7]=0.
- With REG_BANK_BYPASS_EN defined: read r3 and write r3=0x77 in the same cycle -> rd_data=0x77. Without the macro -> old value.
